pc_fetch_sequencer: RTL and testbench

- Controls the program counter and sequences instruction fetch for the MIPS core.
- Sits between the instruction-memory port and decode. Issues fetch requests with a req/ack handshake and holds each fetched word until decode accepts it.
- Applies next-PC redirects from branch, jump and exception sources, and flushes wrong-path fetches.

---
 rtl/pc_fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer: req/ack fetch to instruction memory,
// a single-entry output slot toward decode, and branch/jump/exception redirects with drain.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic [31:0] epc
);

    typedef enum logic [1:0] {StBoot, StFetch, StHold, StDrain} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_epc;
    logic        r_instr_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_consume;
    logic        w_fire;
    logic        w_outstanding;

    assign w_redirect    = exception | jump | branch_taken;
    assign w_target      = exception ? EXC_VECTOR : (jump ? jump_target : branch_target);
    assign w_consume     = r_instr_valid & ~stall;
    assign w_fire        = (r_state == StFetch) & imem_req & imem_ack;
    // Request issued this cycle but not completed: redirect must wait it out in DRAIN.
    assign w_outstanding = (r_state == StFetch) & imem_req & ~imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StBoot;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StBoot: w_state_next = StFetch;
            StFetch: begin
                if (w_redirect) begin
                    w_state_next = w_outstanding ? StDrain : StFetch;
                end else if (r_instr_valid && stall) begin
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (w_redirect || !stall) begin
                    w_state_next = StFetch;
                end
            end
            StDrain: begin
                if (imem_ack) begin
                    w_state_next = StFetch;
                end
            end
            default: w_state_next = StBoot;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        unique case (r_state)
            StFetch: imem_req = ~(r_instr_valid & stall);
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = r_drain_addr;
            end
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_drain_addr  <= 32'h0;
            r_instr       <= 32'h0;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_epc         <= 32'h0;
        end else if (w_redirect) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
            if (exception) begin
                r_epc <= r_instr_valid ? r_instr_pc : r_pc;
            end
            if (w_outstanding) begin
                r_drain_addr <= r_pc;
            end
        end else if (w_fire) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + 32'd4;
        end else if (w_consume) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign epc         = r_epc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; memory returns addr ^ 32'hDEAD_BEEF when acked.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .epc          (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;
        exception = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);

        // Zero-wait memory, no stall
        tick(); #1;
        chk("zw_req0", {31'b0, imem_req}, 32'd1);
        chk("zw_addr0", imem_addr, 32'h0);
        chk("zw_valid0", {31'b0, instr_valid}, 32'd0);
        tick(); #1;
        chk("zw_addr4", imem_addr, 32'h4);
        chk("zw_valid1", {31'b0, instr_valid}, 32'd1);
        chk("zw_ipc0", instr_pc, 32'h0);
        chk("zw_instr0", instr, mem_word(32'h0));
        tick(); #1;
        chk("zw_addr8", imem_addr, 32'h8);
        chk("zw_ipc4", instr_pc, 32'h4);

        // Stall for three cycles with instr_pc=0x8 in the slot; ack while idle is ignored
        tick();
        stall = 1'b1;
        #1;
        chk("st_ipc8", instr_pc, 32'h8);
        chk("st_req_c1", {31'b0, imem_req}, 32'd0);
        tick(); #1;
        chk("st_req_c2", {31'b0, imem_req}, 32'd0);
        chk("st_instr_c2", instr, mem_word(32'h8));
        tick(); #1;
        chk("st_req_c3", {31'b0, imem_req}, 32'd0);
        chk("st_ipc_c3", instr_pc, 32'h8);
        chk("st_valid_c3", {31'b0, instr_valid}, 32'd1);
        tick();
        stall = 1'b0;
        #1;
        chk("st_release_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("st_next_addr", imem_addr, 32'hC);
        chk("st_next_req", {31'b0, imem_req}, 32'd1);
        chk("st_next_valid", {31'b0, instr_valid}, 32'd0);

        // Two-cycle ack latency: address stable, one instruction every three cycles
        tick(); #1;
        chk("lat_addr_w1", imem_addr, 32'hC);
        tick();
        imem_ack = 1'b1;
        #1;
        chk("lat_addr_w2", imem_addr, 32'hC);
        chk("lat_req_w2", {31'b0, imem_req}, 32'd1);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("lat_ipcC", instr_pc, 32'hC);
        chk("lat_addr10", imem_addr, 32'h10);
        tick(); #1;
        chk("lat_valid_clr", {31'b0, instr_valid}, 32'd0);
        tick();
        imem_ack = 1'b1;
        #1;
        chk("lat_addr10_hold", imem_addr, 32'h10);
        tick(); #1;
        chk("lat_ipc10", instr_pc, 32'h10);
        chk("lat_valid10", {31'b0, instr_valid}, 32'd1);

        // Exception with slot valid at 0x10, coinciding with an ack (data discarded)
        exception = 1'b1;
        #1;
        tick();
        exception = 1'b0;
        imem_ack = 1'b0;
        #1;
        chk("exc_epc", epc, 32'h10);
        chk("exc_addr", imem_addr, 32'h80);
        chk("exc_flush", {31'b0, instr_valid}, 32'd0);

        // Jump beats branch with a request outstanding: drain old address
        jump = 1'b1;
        jump_target = 32'h400;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        #1;
        tick();
        jump = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk("drn_addr_old", imem_addr, 32'h80);
        chk("drn_req", {31'b0, imem_req}, 32'd1);
        chk("drn_valid", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        tick(); #1;
        chk("drn_valid_after", {31'b0, instr_valid}, 32'd0);
        chk("drn_new_addr", imem_addr, 32'h400);
        tick(); #1;
        chk("jmp_ipc400", instr_pc, 32'h400);
        chk("jmp_instr400", instr, mem_word(32'h400));

        // PC wrap: jump to the last word, then fetch continues at 0
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        #1;
        tick();
        jump = 1'b0;
        #1;
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid0", {31'b0, instr_valid}, 32'd0);
        tick(); #1;
        chk("wrap_addr0", imem_addr, 32'h0);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);

        // Branch into DRAIN, then exception during DRAIN overwrites pc; epc takes pending pc
        imem_ack = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        #1;
        tick();
        branch_taken = 1'b0;
        exception = 1'b1;
        #1;
        chk("drn2_addr", imem_addr, 32'h0);
        tick();
        exception = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("drn2_epc", epc, 32'h300);
        chk("drn2_addr_hold", imem_addr, 32'h0);
        tick(); #1;
        chk("drn2_new_addr", imem_addr, 32'h80);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("pre_rst_ipc", instr_pc, 32'h80);

        // Asynchronous reset mid-transaction
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_ipc", instr_pc, 32'h0);
        chk("arst_epc", epc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("arst_boot_req", {31'b0, imem_req}, 32'd0);
        tick(); #1;
        chk("arst_first_req", {31'b0, imem_req}, 32'd1);
        chk("arst_first_addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
